// File: rtl/fetch_stage.sv
// Instruction fetch: holds the PC, issues one memory request at a time, buffers replies for decode.
// Optional macro FETCH_ALIGN_CHECK_EN turns misaligned PCs into address-error entries.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        br_redirect,
  input  logic [31:0] br_target,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [5:0]  id_op_code,
  output logic [5:0]  id_funct,
  output logic        id_adel
);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  typedef enum logic {S_REQ, S_WAIT} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic             cancel_q, cancel_d;
  logic             started_q;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0] buf_pc   [BUF_DEPTH];
  logic [31:0] buf_inst [BUF_DEPTH];

  logic        push, pop, hs, has_space, misaligned;
  logic [31:0] push_pc, push_inst;

`ifdef FETCH_ALIGN_CHECK_EN
  logic buf_adel [BUF_DEPTH];
  logic push_adel;
  logic err_done_q, err_done_d;
  assign misaligned = (pc_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign inst_addr = pc_q;
  assign id_valid  = (count_q != '0);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    cancel_d  = cancel_q;
    inst_req  = 1'b0;
    push      = 1'b0;
    push_pc   = req_pc_q;
    push_inst = inst_rdata;
    has_space = started_q && (count_q < DEPTH_C);
`ifdef FETCH_ALIGN_CHECK_EN
    push_adel  = 1'b0;
    err_done_d = err_done_q;
`endif
    case (state_q)
      S_REQ: begin
        if (misaligned) begin
`ifdef FETCH_ALIGN_CHECK_EN
          // A misaligned PC produces a single error entry and then parks until redirected.
          if (has_space && !err_done_q) begin
            push       = 1'b1;
            push_pc    = pc_q;
            push_inst  = 32'h0;
            push_adel  = 1'b1;
            err_done_d = 1'b1;
          end
`endif
        end else begin
          inst_req = has_space;
          if (inst_req && inst_addr_ok) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
            state_d  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          state_d = S_REQ;
          if (cancel_q) cancel_d = 1'b0;
          else          push     = 1'b1;
        end
      end
    endcase

    hs  = inst_req & inst_addr_ok;
    pop = id_valid & id_ready;

    // Redirect overrides everything; an accepted-but-unanswered request must be waited out and dropped.
    if (br_redirect) begin
      pc_d = br_target;
      push = 1'b0;
      pop  = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      err_done_d = 1'b0;
`endif
      if (hs || (state_q == S_WAIT && !inst_data_ok)) begin
        cancel_d = 1'b1;
        state_d  = S_WAIT;
      end else begin
        cancel_d = 1'b0;
        state_d  = S_REQ;
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (br_redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      req_pc_q  <= RESET_PC;
      cancel_q  <= 1'b0;
      started_q <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      err_done_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      cancel_q  <= cancel_d;
      started_q <= 1'b1;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
`ifdef FETCH_ALIGN_CHECK_EN
      err_done_q <= err_done_d;
`endif
    end
  end

  // Buffer payload carries no reset; id_valid qualifies it.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr_q]   <= push_pc;
      buf_inst[wr_ptr_q] <= push_inst;
`ifdef FETCH_ALIGN_CHECK_EN
      buf_adel[wr_ptr_q] <= push_adel;
`endif
    end
  end

  assign id_pc      = id_valid ? buf_pc[rd_ptr_q]   : 32'h0;
  assign id_inst    = id_valid ? buf_inst[rd_ptr_q] : 32'h0;
  assign id_op_code = id_inst[31:26];
  assign id_funct   = id_inst[5:0];
`ifdef FETCH_ALIGN_CHECK_EN
  assign id_adel    = id_valid & buf_adel[rd_ptr_q];
`else
  assign id_adel    = 1'b0;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the instruction decoder.
- Holds the PC and drives an SRAM-style instruction-memory request/response handshake with at most one request outstanding.
- Buffers returned instructions in a small FIFO and presents them to decode over a valid/ready interface, together with the op_code/funct slices the decoder consumes.
- Accepts branch/jump redirects from later stages and discards in-flight wrong-path fetches.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC value loaded at reset.
- BUF_DEPTH, 2, instruction buffer entries (power of two, ≥2).

Ports:
- clk  in  1  single clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- inst_req  out  1  instruction-memory request valid.
- inst_addr  out  32  request address (current PC).
- inst_addr_ok  in  1  request accepted this cycle.
- inst_data_ok  in  1  read data valid this cycle.
- inst_rdata  in  32  read data.
- br_redirect  in  1  redirect fetch (one-cycle pulse).
- br_target  in  32  redirect target PC.
- id_valid  out  1  instruction available to decode.
- id_ready  in  1  decode accepts this cycle.
- id_pc  out  32  PC of presented instruction.
- id_inst  out  32  presented instruction.
- id_op_code  out  6  id_inst[31:26].
- id_funct  out  6  id_inst[5:0].
- id_adel  out  1  fetch address error flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, resetn=0): pc=RESET_PC, FIFO empty, state=REQ, outstanding=0, cancel=0. All outputs 0 except inst_addr=RESET_PC.
- inst_req asserts from the first clock edge after resetn deasserts, when the issue condition holds.
- FSM states: REQ, WAIT.
  - REQ: inst_req=1 iff (fifo_count + outstanding) < BUF_DEPTH; inst_addr=pc. Handshake on inst_req & inst_addr_ok: pc<=pc+4, go to WAIT, outstanding=1, and the request PC is latched.
  - WAIT: inst_req=0. On inst_data_ok: if cancel=1, drop the data and clear cancel; else push {req_pc, inst_rdata}. Return to REQ. inst_data_ok never arrives in the same cycle as the matching addr_ok.
- Decode handshake: a pop occurs on id_valid & id_ready.
  - id_valid = FIFO non-empty.
  - id_pc, id_inst, id_op_code, id_funct come combinationally from the FIFO head and hold stable while id_valid=1 and id_ready=0.
  - Push and pop in the same cycle are legal; count is unchanged.
  - Push when full cannot occur by construction of the issue condition. The bench asserts this.
- Redirect (br_redirect=1) has priority over all other updates that cycle:
  - pc<=br_target.
  - FIFO flushed (count=0); any pop that cycle is ignored.
  - If a request is outstanding, or is handshaking this same cycle, cancel<=1 and state becomes/stays WAIT.
  - If a cancelled request's data_ok coincides with the redirect, the data is dropped and cancel stays 0.
  - Requests issue from br_target no earlier than the next cycle.
- Redirect while already cancelling: cancel stays 1, pc<=latest target.
- The PC wraps modulo 2^32.
- Mid-operation reset abandons any outstanding request. The memory model must drop it as well.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined: in REQ, if pc[1:0]!=0, no memory request is issued. Once FIFO space exists, push {pc, 32'h0} with its adel bit=1; FSM stays in REQ and pc holds until a redirect arrives. id_adel reflects the head entry's adel bit.
- Undefined: pc[1:0] is ignored (the address is driven as-is), there is no adel storage, and id_adel is tied 0.

Test Plan:
- Reset release with addr_ok=1 and data_ok one cycle later, id_ready=1 -> inst_addr sequence BFC00000, BFC00004, BFC00008; id_pc follows the same sequence; id_op_code/id_funct match rdata slices.
- id_ready=0 for 10 cycles -> exactly BUF_DEPTH=2 instructions buffered, inst_req drops to 0, id_pc holds BFC00000; id_ready=1 -> drains in order and fetch resumes.
- br_redirect to 0x80001000 while WAIT -> the next data_ok (rdata=0xDEADBEEF) is dropped, FIFO empty, next inst_addr=0x80001000, first id_pc=0x80001000.
- br_redirect coinciding with inst_addr_ok and with a pop -> FIFO flushed, the accepted request is cancelled, no stale id_valid.
- resetn low for one cycle mid-WAIT -> outputs return to reset values immediately (asynchronously); fetch restarts at BFC00000.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x80000002 -> no inst_req; id_valid=1, id_pc=0x80000002, id_inst=0, id_adel=1.
